// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dual-port data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_AUX = 1'b1;

    // Memory word width and the byte-offset bits that must be zero for an aligned access.
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BYTE_OFS_W = 2;
    localparam int unsigned MEM_AW     = 32;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational arbitration decision: requests (and last grant) -> winning port.
// DM_ARB_RR_EN defined: round-robin between simultaneous requesters.
// DM_ARB_RR_EN undefined: fixed priority, port 0 always wins.
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
`ifdef DM_ARB_RR_EN
    input  port_id_t last,
`endif
    output logic     any,
    output port_id_t winner
);

    // Pick the winner among the active requests.
    always_comb begin
        any    = req0 | req1;
        winner = PORT_CPU;
`ifdef DM_ARB_RR_EN
        if (req0 && req1) begin
            winner = (last == PORT_CPU) ? PORT_AUX : PORT_CPU;
        end else if (req1) begin
            winner = PORT_AUX;
        end
`else
        if (!req0 && req1) begin
            winner = PORT_AUX;
        end
`endif
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter in front of a single-ported data memory.
// Each access walks IDLE -> ACCESS -> DONE; the ack pulse is registered and
// appears during DONE. Misaligned or out-of-range accesses fault: the write is
// suppressed, read data is zero and err is raised with the ack.
// Optional macro DM_ARB_RR_EN selects round-robin instead of fixed priority.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned AW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [31:0]   wd0,
    output logic          ack0,
    output logic [31:0]   rd0,
    output logic          err0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wd1,
    output logic          ack1,
    output logic [31:0]   rd1,
    output logic          err1,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wd,
    output logic          mem_we,
    input  logic [31:0]   mem_rd,
    output logic          busy
);

    state_t        state;
    state_t        state_nxt;

    logic          any_req;
    port_id_t      pick;

    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wd;
    logic [AW-1:0] word_idx;
    logic          sel_fault;

    port_id_t      win_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wd_q;
    logic          fault_q;
    logic [31:0]   rdata_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          err0_q;
    logic          err1_q;

`ifdef DM_ARB_RR_EN
    port_id_t      last_q;

    // Remember the last granted port; resetting to AUX hands the first contention to CPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PORT_AUX;
        end else if (state == IDLE && any_req) begin
            last_q <= pick;
        end
    end

    dm_arb_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .any    (any_req),
        .winner (pick)
    );
`else
    dm_arb_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .any    (any_req),
        .winner (pick)
    );
`endif

    // Route the winning requester's command and classify it as faulting or not.
    always_comb begin
        if (pick == PORT_AUX) begin
            sel_we   = we1;
            sel_addr = addr1;
            sel_wd   = wd1;
        end else begin
            sel_we   = we0;
            sel_addr = addr0;
            sel_wd   = wd0;
        end
        word_idx  = sel_addr >> BYTE_OFS_W;
        sel_fault = (sel_addr[BYTE_OFS_W-1:0] != '0) ||
                    (word_idx >= AW'(DEPTH_WORDS));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: requests are only looked at in IDLE.
    always_comb begin
        state_nxt = IDLE;
        unique case (state)
            IDLE:    state_nxt = any_req ? ACCESS : IDLE;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: the write strobe is gated by reset so a reset in ACCESS kills the write.
    always_comb begin
        busy   = (state != IDLE);
        mem_we = (state == ACCESS) && we_q && !fault_q && !reset;
    end

    // Latch the granted command in IDLE, capture read data and raise ack/err leaving ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q   <= PORT_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        win_q   <= pick;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wd_q    <= sel_wd;
                        fault_q <= sel_fault;
                    end
                end
                ACCESS: begin
                    rdata_q <= (we_q || fault_q) ? '0 : mem_rd;
                    ack0_q  <= (win_q == PORT_CPU);
                    ack1_q  <= (win_q == PORT_AUX);
                    err0_q  <= fault_q && (win_q == PORT_CPU);
                    err1_q  <= fault_q && (win_q == PORT_AUX);
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = 32'(addr_q);
    assign mem_wd   = wd_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign err0     = err0_q;
    assign err1     = err1_q;
    assign rd0      = rdata_q;
    assign rd1      = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed accesses push expected acks and
// memory writes into queues; a monitor pops and compares on every ack / mem_we.
// Expected grant order follows DM_ARB_RR_EN when it is defined for the build.
module tb_dm_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } acc_t;

    logic        clk;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wd0, addr1, wd1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rd0, rd1;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_we;
    logic        busy;

    int          vectors;
    int          miscompares;
    int          cyc;

    exp_t        exp_q[$];
    wr_t         wr_q[$];
    acc_t        acc_q0[$];
    acc_t        acc_q1[$];

    logic [31:0] mem [0:3071];

    dm_arbiter #(.DEPTH_WORDS(3072), .AW(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wd0      (wd0),
        .ack0     (ack0),
        .rd0      (rd0),
        .err0     (err0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wd1      (wd1),
        .ack1     (ack1),
        .rd1      (rd1),
        .err1     (err1),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on the clock edge.
    initial begin
        for (int i = 0; i < 3072; i++) mem[i] = '0;
    end

    always_comb begin
        mem_rd = '0;
        if (mem_addr < 32'd12288) mem_rd = mem[mem_addr[13:2]];
    end

    always @(posedge clk) begin
        if (mem_we && mem_addr < 32'd12288) mem[mem_addr[13:2]] <= mem_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every ack and every memory write must match the head of its queue.
    initial begin
        exp_t        e;
        wr_t         w;
        logic        port;
        logic [31:0] rd;
        logic        err;
        forever begin
            @(negedge clk);
            if (ack0 || ack1) begin
                vectors++;
                port = ack1;
                rd   = ack1 ? rd1 : rd0;
                err  = ack1 ? err1 : err0;
                if (ack0 && ack1) begin
                    miscompares++;
                    $display("FAIL ack_both: got ack0=1 ack1=1, required one ack");
                end else if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL ack_unexpected: got ack on port %0d at cycle %0d, required none", port, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (port !== e.port || rd !== e.rd || err !== e.err || cyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL ack_check: got port=%0d rd=%h err=%0d cyc=%0d, required port=%0d rd=%h err=%0d cyc=%0d",
                                 port, rd, err, cyc, e.port, e.rd, e.err, e.cyc);
                    end
                end
            end
            if (mem_we) begin
                vectors++;
                if (wr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL write_unexpected: got mem_we addr=%h data=%h, required no write", mem_addr, mem_wd);
                end else begin
                    w = wr_q.pop_front();
                    if (mem_addr !== w.addr || mem_wd !== w.data) begin
                        miscompares++;
                        $display("FAIL write_check: got addr=%h data=%h, required addr=%h data=%h",
                                 mem_addr, mem_wd, w.addr, w.data);
                    end
                end
            end
        end
    end

    // Requester agent: works through its queue, holding req from one access into the next.
    task automatic agent(input bit port);
        acc_t a;
        bit   more;
        bit   got;
        more = port ? (acc_q1.size() != 0) : (acc_q0.size() != 0);
        while (more) begin
            if (port) begin
                a = acc_q1.pop_front();
                req1 = 1'b1; we1 = a.we; addr1 = a.addr; wd1 = a.wd;
            end else begin
                a = acc_q0.pop_front();
                req0 = 1'b1; we0 = a.we; addr0 = a.addr; wd0 = a.wd;
            end
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(posedge clk);
                #1;
                got = port ? ack1 : ack0;
            end
            vectors++;
            if (!got) begin
                miscompares++;
                $display("FAIL ack_timeout: got no ack on port %0d, required one within 40 cycles", port);
            end
            more = port ? (acc_q1.size() != 0) : (acc_q0.size() != 0);
        end
        if (port) req1 = 1'b0;
        else      req0 = 1'b0;
    endtask

    task automatic push_exp(input logic port, input logic [31:0] rd, input logic err, input int c);
        exp_t e;
        e.port = port; e.rd = rd; e.err = err; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr; w.data = data;
        wr_q.push_back(w);
    endtask

    task automatic push_acc(input bit port, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        acc_t a;
        a.we = we; a.addr = addr; a.wd = wd;
        if (port) acc_q1.push_back(a);
        else      acc_q0.push_back(a);
    endtask

    // One isolated access from an idle arbiter: ack expected two cycles after req rises.
    task automatic single(input bit port, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input bit exp_write);
        @(posedge clk);
        #1;
        push_exp(port, exp_rd, exp_err, cyc + 2);
        if (exp_write) push_wr(addr, wd);
        push_acc(port, we, addr, wd);
        agent(port);
    endtask

    initial begin
        int          k;
        logic [5:0]  busy_pat;
        logic [3:0]  order;

        vectors = 0; miscompares = 0; cyc = 0;
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wd0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wd1 = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_err0", {31'd0, err0}, 32'd0);
        chk("rst_err1", {31'd0, err1}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_rd0", rd0, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic write then cross-port read.
        single(0, 1, 32'h10, 32'h12345678, 32'h0, 0, 1);
        single(1, 0, 32'h10, 32'h0, 32'h12345678, 0, 0);

        // Fault boundaries: word 3072 and misaligned; last valid word 3071.
        single(0, 1, 32'h3000, 32'hDEADBEEF, 32'h0, 1, 0);
        single(1, 1, 32'h2, 32'hCAFEF00D, 32'h0, 1, 0);
        single(0, 0, 32'h3000, 32'h0, 32'h0, 1, 0);
        single(1, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        single(0, 1, 32'h2FFC, 32'h0BADF00D, 32'h0, 0, 1);
        single(1, 0, 32'h2FFC, 32'h0, 32'h0BADF00D, 0, 0);

        // Contention: both ports hold req through two accesses each.
        single(0, 1, 32'h40, 32'hA0A0A0A0, 32'h0, 0, 1);
        single(1, 1, 32'h44, 32'hB1B1B1B1, 32'h0, 0, 1);
`ifdef DM_ARB_RR_EN
        order = 4'b1010;
`else
        order = 4'b1100;
`endif
        @(posedge clk);
        #1;
        k = cyc;
        for (int i = 0; i < 4; i++) begin
            push_exp(order[i], order[i] ? 32'hB1B1B1B1 : 32'hA0A0A0A0, 0, k + 2 + 3 * i);
        end
        push_acc(0, 0, 32'h40, 32'h0);
        push_acc(0, 0, 32'h40, 32'h0);
        push_acc(1, 0, 32'h44, 32'h0);
        push_acc(1, 0, 32'h44, 32'h0);
        fork
            agent(0);
            agent(1);
        join

        // Back-to-back on port 0 with req held into the IDLE cycle after ack.
        @(posedge clk);
        #1;
        k = cyc;
        busy_pat = 6'b110110;
        push_exp(0, 32'h0, 0, k + 2);
        push_wr(32'h50, 32'h55AA55AA);
        push_exp(0, 32'h55AA55AA, 0, k + 5);
        push_acc(0, 1, 32'h50, 32'h55AA55AA);
        push_acc(0, 0, 32'h50, 32'h0);
        fork
            agent(0);
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk($sformatf("busy_pattern_%0d", i), {31'd0, busy}, {31'd0, busy_pat[i]});
                end
            end
        join

        // Reset during ACCESS of a write to 0x20: no write, no ack.
        @(posedge clk);
        #1;
        req0 = 1; we0 = 1; addr0 = 32'h20; wd0 = 32'h77777777;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_in_access_mem_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req0 = 0; we0 = 0;
        repeat (3) @(posedge clk);
        #1;
        single(0, 0, 32'h20, 32'h0, 32'h0, 0, 0);

        // Reset during DONE: the ack is gone the next cycle.
        single(1, 0, 32'h10, 32'h0, 32'h12345678, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_done_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_in_done_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // First contention after reset goes to port 0.
        @(posedge clk);
        #1;
        k = cyc;
        push_exp(0, 32'hA0A0A0A0, 0, k + 2);
        push_exp(1, 32'hB1B1B1B1, 0, k + 5);
        push_acc(0, 0, 32'h40, 32'h0);
        push_acc(1, 0, 32'h44, 32'h0);
        fork
            agent(0);
            agent(1);
        join

        repeat (4) @(posedge clk);
        #1;
        chk("ack_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("write_queue_drained", 32'(wr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, required finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
